palette_compositor: RTL and testbench
=====================================

// Module: palette_compositor
// PURPOSE
//  Parametrised N-layer palette compositor with a per-layer writable palette RAM and a registered 3-stage pixel pipeline.
//  Sits between the sprite/background address generators and the VGA DAC.
//  Priority: layer 0 is the highest; palette index 0 is transparent.
//  Frame-synchronous fade-to-black/fade-in engine for round transitions (e.g. KO screen).
// PARAMETERS
//  NUM_LAYERS  4         number of composited layers
//  IDX_W       8         palette index width per layer
//  PAL_DEPTH   256       entries per layer palette (<= 2**IDX_W)
//  BG_COLOR    24'h800080  output when every layer is transparent
//  FADE_RATE   2         frames per fade step (>=1)
// PORTS
//  Clk          in   1                    pixel clock
//  Reset        in   1                    synchronous, active-high
//  pix_valid    in   1                    pixel inputs valid this cycle
//  sync_in      in   2                    {vs,hs}, delayed to align with pixel
//  layer_valid  in   NUM_LAYERS           bit i: pixel lies inside layer i
//  layer_idx    in   NUM_LAYERS*IDX_W     layer i index at [i*IDX_W +: IDX_W]
//  pal_we       in   1                    palette write strobe
//  pal_layer    in   $clog2(NUM_LAYERS)   palette bank to write
//  pal_addr     in   IDX_W                palette entry
//  pal_wdata    in   24                   RGB888 {R,G,B}
//  frame_tick   in   1                    1-cycle pulse per frame (vsync edge)
//  fade_out_req in   1                    start fade to black
//  fade_in_req  in   1                    start fade from black
//  fade_busy    out  1                    fade in progress
//  pix_valid_o  out  1                    output pixel valid
//  sync_o       out  2                    sync delayed 3 cycles
//  VGA_R/G/B    out  8 each               composited, faded colour
// BEHAVIOUR
//  Reset: every output 0, pipeline valids 0, fade level = 16 (full), FSM IDLE; palette RAM contents not cleared.
//  Latency: 3 cycles, fixed, from pix_valid/sync_in to pix_valid_o/sync_o.
//  S1: winner = lowest i with layer_valid[i] && idx_i != 0; register winner layer, index, and a hit flag.
//  S2: synchronous palette read of bank[winner][index]. If no hit, select BG_COLOR.
//  S3: each channel = (c * level) >> 4. Product is 13 bits; level 16 yields the channel unchanged. Result is registered to VGA_*.
//  Index >= PAL_DEPTH is treated as transparent.
//  Palette write: 1 cycle, visible to reads on the next cycle. Same-cycle read/write to the same entry returns old data (read-first).
//  pal_layer >= NUM_LAYERS: write ignored.
//  pix_valid = 0: pipeline still advances; VGA_* driven 0 when pix_valid_o = 0.
//  Fade FSM states: IDLE (level 16), FADING_OUT, DARK (level 0), FADING_IN.
//   IDLE + fade_out_req -> FADING_OUT. DARK + fade_in_req -> FADING_IN.
//   Every FADE_RATE frame_ticks, level steps by 1 (down or up).
//   Level reaching 0 -> DARK; level reaching 16 -> IDLE.
//   Requests in any other state are ignored; both asserted together: only the state-legal one acts.
//   Level changes only on frame_tick, so a frame never mixes two levels.
//  fade_busy = 1 in FADING_OUT / FADING_IN.
//  Reset mid-fade: immediate return to IDLE, level 16.
// CONFIGURATION
//  COMPOSITOR_FADE_EN defined: fade FSM as above.
//  Not defined: level tied to 16, fade ports ignored, fade_busy = 0. S3 stage kept, so latency is still 3.
// STRUCTURE
//  compositor_pkg: fade_state_t enum; FADE_FULL = 5'd16; rgb_t packed struct {r,g,b}; function scale_ch(c, level).
//  Sub-module palette_bank: one PAL_DEPTH x 24 single-write, single-read, read-first RAM.
//  Instantiated NUM_LAYERS times via generate; S2 muxes the bank outputs.
// TESTING
//  1. Load bank0[5]=24'hF8F8E8; layer_valid=4'b0001, idx0=5 -> 3 cycles later RGB=F8,F8,E8.
//  2. layer_valid=4'b0011, idx0=0, idx1=3, bank1[3]=24'hA80000 -> A8,00,00. idx0=0 on all layers -> 80,00,80.
//  3. Write bank0[7]=24'h112233 in the same cycle as a read of bank0[7] -> old value out; next read -> 11,22,33.
//  4. FADE_EN, FADE_RATE=2, pixel FFFFFF, fade_out_req -> 8 ticks: level 12, RGB BF; 32 ticks: DARK, 00; fade_busy drops.
//  5. fade_in_req in IDLE -> ignored. Reset in FADING_OUT -> next cycle IDLE, level 16, outputs 0.
//  6. Random layer streams vs. reference model: sync_o == sync_in delayed 3; pix_valid_o aligned every cycle.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types and helpers for the palette compositor: fade states, RGB payload, channel scaling.
package compositor_pkg;

  localparam logic [4:0] FADE_FULL = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    FADING_OUT,
    DARK,
    FADING_IN
  } fade_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Scale one channel by level/16; level 16 passes the channel through unchanged.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [4:0] level);
    logic [12:0] prod;
    prod = 13'(c) * 13'(level);
    return 8'(prod >> 4);
  endfunction

endpackage

// File: rtl/palette_bank.sv
// One palette bank: single write port, single synchronous read port, read-first on collisions.
module palette_bank
  import compositor_pkg::*;
#(
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned PAL_DEPTH = 256
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [23:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [23:0]      rdata
);

  rgb_t mem [PAL_DEPTH];

  // Read and write share one edge; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < PAL_DEPTH)) begin
      mem[waddr] <= rgb_t'(wdata);
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/palette_compositor.sv
// N-layer palette compositor: priority select, palette lookup, fade scaling (3-cycle pipeline).
// Optional frame-synchronous fade engine enabled by defining COMPOSITOR_FADE_EN.
module palette_compositor
  import compositor_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned PAL_DEPTH  = 256,
  parameter logic [23:0] BG_COLOR   = 24'h800080,
  parameter int unsigned FADE_RATE  = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          pix_valid,
  input  logic [1:0]                    sync_in,
  input  logic [NUM_LAYERS-1:0]         layer_valid,
  input  logic [NUM_LAYERS*IDX_W-1:0]   layer_idx,
  input  logic                          pal_we,
  input  logic [$clog2(NUM_LAYERS)-1:0] pal_layer,
  input  logic [IDX_W-1:0]              pal_addr,
  input  logic [23:0]                   pal_wdata,
  input  logic                          frame_tick,
  input  logic                          fade_out_req,
  input  logic                          fade_in_req,
  output logic                          fade_busy,
  output logic                          pix_valid_o,
  output logic [1:0]                    sync_o,
  output logic [7:0]                    VGA_R,
  output logic [7:0]                    VGA_G,
  output logic [7:0]                    VGA_B
);

  localparam int unsigned LW     = $clog2(NUM_LAYERS);
  localparam int unsigned RATE_W = (FADE_RATE > 1) ? $clog2(FADE_RATE) : 1;

  logic [4:0] level;

  // ---------------- S1: priority winner ----------------
  logic             win_hit;
  logic [LW-1:0]    win_layer;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  // Scan from the lowest priority upward so the lowest qualifying layer overwrites last.
  always_comb begin
    win_hit   = 1'b0;
    win_layer = '0;
    win_idx   = '0;
    cand      = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      cand = layer_idx[i*IDX_W +: IDX_W];
      if (layer_valid[i] && (cand != '0) && (32'(cand) < PAL_DEPTH)) begin
        win_hit   = 1'b1;
        win_layer = LW'(i);
        win_idx   = cand;
      end
    end
  end

  logic             s1_valid;
  logic [1:0]       s1_sync;
  logic             s1_hit;
  logic [LW-1:0]    s1_layer;
  logic [IDX_W-1:0] s1_idx;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_sync  <= 2'b00;
      s1_hit   <= 1'b0;
      s1_layer <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_sync  <= sync_in;
      s1_hit   <= win_hit;
      s1_layer <= win_layer;
      s1_idx   <= win_idx;
    end
  end

  // ---------------- S2: palette read ----------------
  logic [23:0] bank_rd [NUM_LAYERS];

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_bank
    palette_bank #(
      .IDX_W     (IDX_W),
      .PAL_DEPTH (PAL_DEPTH)
    ) u_bank (
      .clk   (Clk),
      .we    (pal_we && (pal_layer == LW'(g))),
      .waddr (pal_addr),
      .wdata (pal_wdata),
      .raddr (s1_idx),
      .rdata (bank_rd[g])
    );
  end

  logic          s2_valid;
  logic [1:0]    s2_sync;
  logic          s2_hit;
  logic [LW-1:0] s2_layer;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s2_valid <= 1'b0;
      s2_sync  <= 2'b00;
      s2_hit   <= 1'b0;
      s2_layer <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sync  <= s1_sync;
      s2_hit   <= s1_hit;
      s2_layer <= s1_layer;
    end
  end

  // ---------------- S3: background select, fade scale, output ----------------
  rgb_t s3_color;

  always_comb begin
    s3_color = rgb_t'(BG_COLOR);
    if (s2_hit) begin
      s3_color = rgb_t'(bank_rd[s2_layer]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_valid_o <= 1'b0;
      sync_o      <= 2'b00;
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
    end else begin
      pix_valid_o <= s2_valid;
      sync_o      <= s2_sync;
      if (s2_valid) begin
        VGA_R <= scale_ch(s3_color.r, level);
        VGA_G <= scale_ch(s3_color.g, level);
        VGA_B <= scale_ch(s3_color.b, level);
      end else begin
        VGA_R <= 8'h00;
        VGA_G <= 8'h00;
        VGA_B <= 8'h00;
      end
    end
  end

  // ---------------- Fade engine ----------------
`ifdef COMPOSITOR_FADE_EN
  fade_state_t       state_q, state_d;
  logic [4:0]        level_q, level_d;
  logic [RATE_W-1:0] tick_q, tick_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      level_q   <= FADE_FULL;
      tick_q    <= '0;
      fade_busy <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      tick_q    <= tick_d;
      fade_busy <= (state_d == FADING_OUT) || (state_d == FADING_IN);
    end
  end

  // Level only moves on frame_tick, once every FADE_RATE ticks.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tick_d  = tick_q;
    unique case (state_q)
      IDLE: begin
        if (fade_out_req) begin
          state_d = FADING_OUT;
          tick_d  = '0;
        end
      end
      FADING_OUT: begin
        if (frame_tick) begin
          if (tick_q == RATE_W'(FADE_RATE - 1)) begin
            tick_d  = '0;
            level_d = level_q - 5'd1;
            if (level_q == 5'd1) begin
              state_d = DARK;
            end
          end else begin
            tick_d = tick_q + RATE_W'(1);
          end
        end
      end
      DARK: begin
        if (fade_in_req) begin
          state_d = FADING_IN;
          tick_d  = '0;
        end
      end
      FADING_IN: begin
        if (frame_tick) begin
          if (tick_q == RATE_W'(FADE_RATE - 1)) begin
            tick_d  = '0;
            level_d = level_q + 5'd1;
            if (level_q == FADE_FULL - 5'd1) begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + RATE_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        level_d = FADE_FULL;
        tick_d  = '0;
      end
    endcase
  end

  assign level = level_q;
`else
  logic unused_fade;
  assign unused_fade = ^{frame_tick, fade_out_req, fade_in_req};
  assign level       = FADE_FULL;

  always_ff @(posedge Clk) begin
    fade_busy <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_palette_compositor.sv
// Directed self-checking bench for palette_compositor; fade scenarios run when COMPOSITOR_FADE_EN is defined.
module tb_palette_compositor;

  logic        Clk;
  logic        Reset;
  logic        pix_valid;
  logic [1:0]  sync_in;
  logic [3:0]  layer_valid;
  logic [31:0] layer_idx;
  logic        pal_we;
  logic [1:0]  pal_layer;
  logic [7:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic        frame_tick;
  logic        fade_out_req;
  logic        fade_in_req;
  logic        fade_busy;
  logic        pix_valid_o;
  logic [1:0]  sync_o;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  int checks;
  int errors;

  palette_compositor #(
    .NUM_LAYERS (4),
    .IDX_W      (8),
    .PAL_DEPTH  (256),
    .BG_COLOR   (24'h800080),
    .FADE_RATE  (2)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .pix_valid    (pix_valid),
    .sync_in      (sync_in),
    .layer_valid  (layer_valid),
    .layer_idx    (layer_idx),
    .pal_we       (pal_we),
    .pal_layer    (pal_layer),
    .pal_addr     (pal_addr),
    .pal_wdata    (pal_wdata),
    .frame_tick   (frame_tick),
    .fade_out_req (fade_out_req),
    .fade_in_req  (fade_in_req),
    .fade_busy    (fade_busy),
    .pix_valid_o  (pix_valid_o),
    .sync_o       (sync_o),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic pal_write(input logic [1:0] layer, input logic [7:0] addr, input logic [23:0] data);
    pal_we    = 1'b1;
    pal_layer = layer;
    pal_addr  = addr;
    pal_wdata = data;
    cycle();
    pal_we    = 1'b0;
  endtask

  task automatic set_pix(input logic pv, input logic [1:0] s, input logic [3:0] lv, input logic [31:0] idx);
    pix_valid   = pv;
    sync_in     = s;
    layer_valid = lv;
    layer_idx   = idx;
  endtask

  // Present one pixel for one cycle, then idle until it reaches the outputs.
  task automatic send_pixel(input logic [1:0] s, input logic [3:0] lv, input logic [31:0] idx);
    set_pix(1'b1, s, lv, idx);
    cycle();
    set_pix(1'b0, 2'b00, 4'b0000, 32'h0);
    cycle();
    cycle();
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    cycle();
    cycle();
    cycle();
    checks++;
    if (pix_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", pix_valid_o);
    end
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_rgb: got %h%h%h expected 000000", VGA_R, VGA_G, VGA_B);
    end
    checks++;
    if (sync_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_sync: got %b expected 00", sync_o);
    end
    checks++;
    if (fade_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", fade_busy);
    end
    Reset = 1'b0;
    cycle();
  endtask

  task automatic test_single_layer();
    pal_write(2'd0, 8'd5, 24'hF8F8E8);
    send_pixel(2'b10, 4'b0001, 32'h0000_0005);
    checks++;
    if (pix_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL single_valid: got %b expected 1", pix_valid_o);
    end
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hF8F8E8) begin
      errors++;
      $display("FAIL single_rgb: got %h%h%h expected f8f8e8", VGA_R, VGA_G, VGA_B);
    end
    checks++;
    if (sync_o !== 2'b10) begin
      errors++;
      $display("FAIL single_sync: got %b expected 10", sync_o);
    end
    cycle();
    checks++;
    if ({pix_valid_o, VGA_R, VGA_G, VGA_B} !== 25'h0) begin
      errors++;
      $display("FAIL single_idle: got %b %h%h%h expected 0 000000", pix_valid_o, VGA_R, VGA_G, VGA_B);
    end
  endtask

  task automatic test_priority();
    pal_write(2'd1, 8'd3, 24'hA80000);
    send_pixel(2'b00, 4'b0011, 32'h0000_0300);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hA80000) begin
      errors++;
      $display("FAIL prio_transparent0: got %h%h%h expected a80000", VGA_R, VGA_G, VGA_B);
    end
    send_pixel(2'b00, 4'b1111, 32'h0000_0000);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h800080) begin
      errors++;
      $display("FAIL prio_all_transparent: got %h%h%h expected 800080", VGA_R, VGA_G, VGA_B);
    end
    send_pixel(2'b00, 4'b0011, 32'h0000_0305);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hF8F8E8) begin
      errors++;
      $display("FAIL prio_layer0_wins: got %h%h%h expected f8f8e8", VGA_R, VGA_G, VGA_B);
    end
    send_pixel(2'b00, 4'b0000, 32'h0000_0305);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h800080) begin
      errors++;
      $display("FAIL prio_no_layer_valid: got %h%h%h expected 800080", VGA_R, VGA_G, VGA_B);
    end
  endtask

  // The palette is read one cycle after the pixel enters, so the write lands on that same edge.
  task automatic test_read_first();
    pal_write(2'd0, 8'd7, 24'hAABBCC);
    set_pix(1'b1, 2'b00, 4'b0001, 32'h0000_0007);
    cycle();
    set_pix(1'b0, 2'b00, 4'b0000, 32'h0);
    pal_we    = 1'b1;
    pal_layer = 2'd0;
    pal_addr  = 8'd7;
    pal_wdata = 24'h112233;
    cycle();
    pal_we = 1'b0;
    cycle();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hAABBCC) begin
      errors++;
      $display("FAIL rf_old_data: got %h%h%h expected aabbcc", VGA_R, VGA_G, VGA_B);
    end
    send_pixel(2'b00, 4'b0001, 32'h0000_0007);
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h112233) begin
      errors++;
      $display("FAIL rf_new_data: got %h%h%h expected 112233", VGA_R, VGA_G, VGA_B);
    end
  endtask

  // Back-to-back pixels, one per cycle; each emerges three cycles after it enters.
  task automatic test_back_to_back();
    logic        v_pv  [8];
    logic [1:0]  v_sy  [8];
    logic [3:0]  v_lv  [8];
    logic [31:0] v_idx [8];
    logic [23:0] v_rgb [8];
    pal_write(2'd2, 8'd9, 24'h0055AA);
    pal_write(2'd3, 8'd1, 24'h123456);
    v_pv[0] = 1'b1; v_sy[0] = 2'b00; v_lv[0] = 4'b1111; v_idx[0] = 32'h0109_0305; v_rgb[0] = 24'hF8F8E8;
    v_pv[1] = 1'b1; v_sy[1] = 2'b01; v_lv[1] = 4'b1110; v_idx[1] = 32'h0109_0305; v_rgb[1] = 24'hA80000;
    v_pv[2] = 1'b1; v_sy[2] = 2'b10; v_lv[2] = 4'b1100; v_idx[2] = 32'h0109_0305; v_rgb[2] = 24'h0055AA;
    v_pv[3] = 1'b0; v_sy[3] = 2'b11; v_lv[3] = 4'b1111; v_idx[3] = 32'h0109_0305; v_rgb[3] = 24'h000000;
    v_pv[4] = 1'b1; v_sy[4] = 2'b11; v_lv[4] = 4'b1000; v_idx[4] = 32'h0109_0305; v_rgb[4] = 24'h123456;
    v_pv[5] = 1'b1; v_sy[5] = 2'b00; v_lv[5] = 4'b1111; v_idx[5] = 32'h0100_0000; v_rgb[5] = 24'h123456;
    v_pv[6] = 1'b1; v_sy[6] = 2'b01; v_lv[6] = 4'b0111; v_idx[6] = 32'h0100_0000; v_rgb[6] = 24'h800080;
    v_pv[7] = 1'b1; v_sy[7] = 2'b10; v_lv[7] = 4'b0101; v_idx[7] = 32'h0009_0007; v_rgb[7] = 24'h112233;
    for (int m = 0; m < 10; m++) begin
      if (m < 8) begin
        set_pix(v_pv[m], v_sy[m], v_lv[m], v_idx[m]);
      end else begin
        set_pix(1'b0, 2'b00, 4'b0000, 32'h0);
      end
      cycle();
      if (m >= 2) begin
        checks++;
        if (pix_valid_o !== v_pv[m-2]) begin
          errors++;
          $display("FAIL b2b_valid[%0d]: got %b expected %b", m - 2, pix_valid_o, v_pv[m-2]);
        end
        checks++;
        if (sync_o !== v_sy[m-2]) begin
          errors++;
          $display("FAIL b2b_sync[%0d]: got %b expected %b", m - 2, sync_o, v_sy[m-2]);
        end
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== v_rgb[m-2]) begin
          errors++;
          $display("FAIL b2b_rgb[%0d]: got %h%h%h expected %h", m - 2, VGA_R, VGA_G, VGA_B, v_rgb[m-2]);
        end
      end
    end
  endtask

  // Steady white pixel stream used by the fade scenarios.
  task automatic start_white_stream();
    pal_write(2'd0, 8'd2, 24'hFFFFFF);
    set_pix(1'b1, 2'b00, 4'b0001, 32'h0000_0002);
    cycle();
    cycle();
    cycle();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL white_full: got %h%h%h expected ffffff", VGA_R, VGA_G, VGA_B);
    end
  endtask

`ifdef COMPOSITOR_FADE_EN
  task automatic test_fade_ignore();
    fade_in_req = 1'b1;
    cycle();
    fade_in_req = 1'b0;
    cycle();
    checks++;
    if (fade_busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy: got %b expected 0", fade_busy);
    end
    for (int k = 0; k < 4; k++) frame_pulse();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL ignore_rgb: got %h%h%h expected ffffff", VGA_R, VGA_G, VGA_B);
    end
  endtask

  task automatic test_fade_out_in();
    fade_out_req = 1'b1;
    fade_in_req  = 1'b1;
    cycle();
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
    checks++;
    if (fade_busy !== 1'b1) begin
      errors++;
      $display("FAIL out_busy_start: got %b expected 1", fade_busy);
    end
    for (int k = 0; k < 8; k++) frame_pulse();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hBFBFBF) begin
      errors++;
      $display("FAIL out_level12: got %h%h%h expected bfbfbf", VGA_R, VGA_G, VGA_B);
    end
    for (int k = 0; k < 23; k++) frame_pulse();
    checks++;
    if ({fade_busy, VGA_R} !== 9'h10F) begin
      errors++;
      $display("FAIL out_level1: got busy %b r %h expected busy 1 r 0f", fade_busy, VGA_R);
    end
    frame_pulse();
    checks++;
    if (fade_busy !== 1'b0) begin
      errors++;
      $display("FAIL out_dark_busy: got %b expected 0", fade_busy);
    end
    checks++;
    if ({pix_valid_o, VGA_R, VGA_G, VGA_B} !== 25'h1000000) begin
      errors++;
      $display("FAIL out_dark_rgb: got %b %h%h%h expected 1 000000", pix_valid_o, VGA_R, VGA_G, VGA_B);
    end
    fade_in_req = 1'b1;
    cycle();
    fade_in_req = 1'b0;
    checks++;
    if (fade_busy !== 1'b1) begin
      errors++;
      $display("FAIL in_busy_start: got %b expected 1", fade_busy);
    end
    for (int k = 0; k < 8; k++) frame_pulse();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h3F3F3F) begin
      errors++;
      $display("FAIL in_level4: got %h%h%h expected 3f3f3f", VGA_R, VGA_G, VGA_B);
    end
    for (int k = 0; k < 24; k++) frame_pulse();
    checks++;
    if ({fade_busy, VGA_R, VGA_G, VGA_B} !== 25'h0FFFFFF) begin
      errors++;
      $display("FAIL in_full: got busy %b %h%h%h expected busy 0 ffffff", fade_busy, VGA_R, VGA_G, VGA_B);
    end
  endtask

  task automatic test_reset_mid_fade();
    fade_out_req = 1'b1;
    cycle();
    fade_out_req = 1'b0;
    for (int k = 0; k < 4; k++) frame_pulse();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hDFDFDF) begin
      errors++;
      $display("FAIL mid_level14: got %h%h%h expected dfdfdf", VGA_R, VGA_G, VGA_B);
    end
    Reset = 1'b1;
    cycle();
    checks++;
    if ({fade_busy, pix_valid_o, VGA_R, VGA_G, VGA_B} !== 26'h0) begin
      errors++;
      $display("FAIL mid_reset: got busy %b valid %b %h%h%h expected all 0", fade_busy, pix_valid_o, VGA_R, VGA_G, VGA_B);
    end
    Reset = 1'b0;
    cycle();
    cycle();
    cycle();
    checks++;
    if ({fade_busy, VGA_R, VGA_G, VGA_B} !== 25'h0FFFFFF) begin
      errors++;
      $display("FAIL mid_recover: got busy %b %h%h%h expected busy 0 ffffff", fade_busy, VGA_R, VGA_G, VGA_B);
    end
  endtask
`else
  task automatic test_fade_disabled();
    fade_out_req = 1'b1;
    cycle();
    fade_out_req = 1'b0;
    checks++;
    if (fade_busy !== 1'b0) begin
      errors++;
      $display("FAIL nofade_busy: got %b expected 0", fade_busy);
    end
    for (int k = 0; k < 8; k++) frame_pulse();
    checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL nofade_rgb: got %h%h%h expected ffffff", VGA_R, VGA_G, VGA_B);
    end
  endtask

  task automatic test_reset_mid_stream();
    Reset = 1'b1;
    cycle();
    checks++;
    if ({pix_valid_o, VGA_R, VGA_G, VGA_B} !== 25'h0) begin
      errors++;
      $display("FAIL stream_reset: got %b %h%h%h expected 0 000000", pix_valid_o, VGA_R, VGA_G, VGA_B);
    end
    Reset = 1'b0;
    cycle();
    cycle();
    cycle();
    checks++;
    if ({pix_valid_o, VGA_R, VGA_G, VGA_B} !== 25'h1FFFFFF) begin
      errors++;
      $display("FAIL stream_recover: got %b %h%h%h expected 1 ffffff", pix_valid_o, VGA_R, VGA_G, VGA_B);
    end
  endtask
`endif

  initial begin
    checks       = 0;
    errors       = 0;
    Reset        = 1'b1;
    pal_we       = 1'b0;
    pal_layer    = 2'd0;
    pal_addr     = 8'd0;
    pal_wdata    = 24'h0;
    frame_tick   = 1'b0;
    fade_out_req = 1'b0;
    fade_in_req  = 1'b0;
    set_pix(1'b0, 2'b00, 4'b0000, 32'h0);

    test_reset();
    test_single_layer();
    test_priority();
    test_read_first();
    test_back_to_back();
    start_white_stream();
`ifdef COMPOSITOR_FADE_EN
    test_fade_ignore();
    test_fade_out_in();
    test_reset_mid_fade();
`else
    test_fade_disabled();
    test_reset_mid_stream();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
